// File: rtl/uart_pkg.sv
// UART shared types: transmitter FSM states and line-mux select encodings.
package uart_pkg;

  // Line mux select encodings seen by the TX line mux.
  localparam logic [1:0] LINE_MARK   = 2'b00;
  localparam logic [1:0] LINE_START  = 2'b01;
  localparam logic [1:0] LINE_DATA   = 2'b10;
  localparam logic [1:0] LINE_PARITY = 2'b11;

  typedef enum logic [1:0] {
    SEL_MARK   = LINE_MARK,
    SEL_START  = LINE_START,
    SEL_DATA   = LINE_DATA,
    SEL_PARITY = LINE_PARITY
  } tx_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CTS_WAIT = 3'd1,
    ST_LOAD     = 3'd2,
    ST_START    = 3'd3,
    ST_DATA     = 3'd4,
    ST_PARITY   = 3'd5,
    ST_STOP     = 3'd6
  } tx_state_t;

endpackage

// File: rtl/transmitter_controller.sv
// UART TX sequencer: pops a word from the FIFO into the shifter and steers the
// line mux through start/data/parity/stop, one bit per baud tick, under CTS.
module transmitter_controller
  import uart_pkg::*;
#(
  parameter int DBITS_W    = 2,
  parameter int DBITS_BASE = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tx_en_i,
  input  logic               cts_ni,
  input  logic               baud_tick_i,
  input  logic               fifo_empty_i,
  input  logic [DBITS_W-1:0] data_bits_i,
  input  logic               parity_en_i,
  input  logic               stop2_i,
  output logic               fifo_rd_o,
  output logic               load_o,
  output logic               shift_o,
  output logic [1:0]         tx_sel_o,
  output logic               busy_o,
  output logic               tx_done_o
);

  localparam int CNT_W = $clog2(DBITS_BASE + 2**DBITS_W);

  tx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic [DBITS_W-1:0] shadow_dbits_q, shadow_dbits_d;
  logic               shadow_par_q, shadow_par_d;
  logic               shadow_stop2_q, shadow_stop2_d;

  logic [CNT_W-1:0]   last_idx;
  logic               last_bit;
  logic               can_send;

  // Index of the final data bit for the word length latched at LOAD.
  assign last_idx = CNT_W'(DBITS_BASE - 1) + CNT_W'(shadow_dbits_q);
  assign last_bit = (bit_cnt_q == last_idx);
  assign can_send = ~cts_ni & ~fifo_empty_i;

  // State, counters and shadow configuration; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      stop_cnt_q     <= 1'b0;
      shadow_dbits_q <= '0;
      shadow_par_q   <= 1'b0;
      shadow_stop2_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      stop_cnt_q     <= stop_cnt_d;
      shadow_dbits_q <= shadow_dbits_d;
      shadow_par_q   <= shadow_par_d;
      shadow_stop2_q <= shadow_stop2_d;
    end
  end

  // Next-state and output decode; shift and done are tick-qualified (Mealy).
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    stop_cnt_d     = stop_cnt_q;
    shadow_dbits_d = shadow_dbits_q;
    shadow_par_d   = shadow_par_q;
    shadow_stop2_d = shadow_stop2_q;
    fifo_rd_o      = 1'b0;
    load_o         = 1'b0;
    shift_o        = 1'b0;
    tx_sel_o       = SEL_MARK;
    busy_o         = 1'b0;
    tx_done_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_en_i) state_d = ST_CTS_WAIT;
      end

      ST_CTS_WAIT: begin
        // Leaving on a tick keeps the start bit aligned to a full bit period.
        if (!tx_en_i)                     state_d = ST_IDLE;
        else if (can_send && baud_tick_i) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        fifo_rd_o      = 1'b1;
        load_o         = 1'b1;
        tx_sel_o       = SEL_START;
        busy_o         = 1'b1;
        shadow_dbits_d = data_bits_i;
        shadow_par_d   = parity_en_i;
        shadow_stop2_d = stop2_i;
        state_d        = ST_START;
      end

      ST_START: begin
        tx_sel_o = SEL_START;
        busy_o   = 1'b1;
        if (baud_tick_i) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end

      ST_DATA: begin
        tx_sel_o = SEL_DATA;
        busy_o   = 1'b1;
        if (baud_tick_i) begin
          shift_o = 1'b1;
          if (last_bit) begin
            if (shadow_par_q) begin
              state_d = ST_PARITY;
            end else begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PARITY: begin
        tx_sel_o = SEL_PARITY;
        busy_o   = 1'b1;
        if (baud_tick_i) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end

      ST_STOP: begin
        tx_sel_o = SEL_MARK;
        busy_o   = 1'b1;
        if (baud_tick_i) begin
          if (stop_cnt_q == shadow_stop2_q) begin
            tx_done_o = 1'b1;
            // Chain straight into the next frame when nothing holds it back.
            if (tx_en_i && can_send) state_d = ST_LOAD;
            else if (tx_en_i)        state_d = ST_CTS_WAIT;
            else                     state_d = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
